// File: rtl/gba_cart_bus_frontend.sv
// rtl/gba_cart_bus_frontend.sv - GBA cartridge ROM-bus (CS1) front end: sync, address tracking, memory requests
module gba_cart_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cart_cs_n,
    input  logic              cart_rd_n,
    input  logic              cart_wr_n,
    input  logic [15:0]       cart_ad_in,
    input  logic [7:0]        cart_a_hi,
    output logic [15:0]       cart_ad_out,
    output logic              cart_ad_oe,
    output logic              from_cart,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_we,
    output logic [15:0]       req_wdata,
    input  logic              rsp_valid,
    input  logic [15:0]       rsp_data,
    output logic              underrun,
    input  logic              underrun_clr
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RSP, READY, WRITE, DRAIN} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic [15:0]            ad_pipe  [SYNC_STAGES];
    logic [7:0]             ahi_pipe [SYNC_STAGES];
    logic                   s_cs, s_rd, s_wr, cs_d, rd_d, wr_d;
    logic [15:0]            s_ad;
    logic [7:0]             s_ahi;
    logic                   cs_fall, cs_rise, rd_rise, wr_rise;

    logic [23:0] hw_addr, hw_inc, hw_next, req_hw;
    logic [15:0] data_reg, wd_cap;
    logic        discard, dr_req, dr_we, dr_rsp;
    logic        dr_req_n, dr_we_n, dr_rsp_n;
    logic        latch_addr, inc_addr, load_req, load_wdata, take_data;
    logic        set_discard, clr_discard, set_underrun;

    // Strobes reset high (inactive); bus data follows through an equal-depth pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_pipe[i]  <= '0;
                ahi_pipe[i] <= '0;
            end
            cs_d <= 1'b1;
            rd_d <= 1'b1;
            wr_d <= 1'b1;
        end else begin
            cs_sync[0]  <= cart_cs_n;
            rd_sync[0]  <= cart_rd_n;
            wr_sync[0]  <= cart_wr_n;
            ad_pipe[0]  <= cart_ad_in;
            ahi_pipe[0] <= cart_a_hi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]  <= cs_sync[i-1];
                rd_sync[i]  <= rd_sync[i-1];
                wr_sync[i]  <= wr_sync[i-1];
                ad_pipe[i]  <= ad_pipe[i-1];
                ahi_pipe[i] <= ahi_pipe[i-1];
            end
            cs_d <= s_cs;
            rd_d <= s_rd;
            wr_d <= s_wr;
        end
    end

    assign s_cs  = cs_sync[SYNC_STAGES-1];
    assign s_rd  = rd_sync[SYNC_STAGES-1];
    assign s_wr  = wr_sync[SYNC_STAGES-1];
    assign s_ad  = ad_pipe[SYNC_STAGES-1];
    assign s_ahi = ahi_pipe[SYNC_STAGES-1];

    assign cs_fall = cs_d & ~s_cs;
    assign cs_rise = ~cs_d & s_cs;
    assign rd_rise = ~rd_d & s_rd;
    assign wr_rise = ~wr_d & s_wr;

    // Only the low halfword counts, so a burst wraps inside its 128 KB window.
    assign hw_inc  = {hw_addr[23:16], hw_addr[15:0] + 16'd1};
    assign hw_next = latch_addr ? {s_ahi, s_ad} : (inc_addr ? hw_inc : hw_addr);

    always_comb begin
        state_next   = state;
        latch_addr   = 1'b0;
        inc_addr     = 1'b0;
        load_req     = 1'b0;
        load_wdata   = 1'b0;
        take_data    = 1'b0;
        set_discard  = 1'b0;
        clr_discard  = 1'b0;
        set_underrun = 1'b0;
        dr_req_n     = dr_req;
        dr_we_n      = dr_we;
        dr_rsp_n     = dr_rsp;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    latch_addr = 1'b1;
                    load_req   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (cs_rise) begin
                    state_next  = DRAIN;
                    clr_discard = 1'b1;
                    dr_req_n    = ~req_ready;
                    dr_we_n     = 1'b0;
                    dr_rsp_n    = req_ready;
                end else begin
                    if (rd_rise) begin
                        set_underrun = 1'b1;
                        inc_addr     = 1'b1;
                        set_discard  = 1'b1;
                    end
                    if (req_ready) state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (cs_rise) begin
                    state_next  = DRAIN;
                    clr_discard = 1'b1;
                    dr_req_n    = 1'b0;
                    dr_we_n     = 1'b0;
                    dr_rsp_n    = ~rsp_valid;
                end else begin
                    if (rd_rise) begin
                        set_underrun = 1'b1;
                        inc_addr     = 1'b1;
                    end
                    if (rsp_valid) begin
                        if (discard || rd_rise) begin
                            clr_discard = 1'b1;
                            load_req    = 1'b1;
                            state_next  = FETCH;
                        end else begin
                            take_data  = 1'b1;
                            state_next = READY;
                        end
                    end else if (rd_rise) begin
                        set_discard = 1'b1;
                    end
                end
            end
            READY: begin
                if (cs_rise) begin
                    state_next = DRAIN;
                    dr_req_n   = 1'b0;
                    dr_we_n    = 1'b0;
                    dr_rsp_n   = 1'b0;
                end else if (rd_rise) begin
                    inc_addr   = 1'b1;
                    load_req   = 1'b1;
                    state_next = FETCH;
                end else if (wr_rise && s_rd) begin
                    load_req   = 1'b1;
                    load_wdata = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (cs_rise) begin
                    state_next = DRAIN;
                    dr_req_n   = ~req_ready;
                    dr_we_n    = 1'b1;
                    dr_rsp_n   = 1'b0;
                end else if (req_ready) begin
                    inc_addr   = 1'b1;
                    load_req   = 1'b1;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                // A read accepted here still owes a response that must be swallowed.
                dr_req_n = dr_req & ~req_ready;
                dr_rsp_n = (dr_rsp & ~rsp_valid) | (dr_req & req_ready & ~dr_we);
                if (!dr_req_n && !dr_rsp_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hw_addr   <= '0;
            req_hw    <= '0;
            data_reg  <= '0;
            wd_cap    <= '0;
            req_wdata <= '0;
            discard   <= 1'b0;
            dr_req    <= 1'b0;
            dr_we     <= 1'b0;
            dr_rsp    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state   <= state_next;
            hw_addr <= hw_next;
            dr_req  <= dr_req_n;
            dr_we   <= dr_we_n;
            dr_rsp  <= dr_rsp_n;
            if (load_req)   req_hw    <= hw_next;
            if (take_data)  data_reg  <= rsp_data;
            if (!s_wr)      wd_cap    <= s_ad;
            if (load_wdata) req_wdata <= wd_cap;
            if (set_discard)      discard <= 1'b1;
            else if (clr_discard) discard <= 1'b0;
            if (set_underrun)      underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    assign from_cart   = (state != IDLE);
    assign cart_ad_out = data_reg;
    assign cart_ad_oe  = ~s_cs & ~s_rd & (state != DRAIN);
    assign req_valid   = (state == FETCH) | (state == WRITE) | ((state == DRAIN) & dr_req);
    assign req_we      = (state == WRITE) | ((state == DRAIN) & dr_req & dr_we);
    assign req_addr    = ADDR_W'({1'b0, req_hw, 1'b0});

endmodule

// File: tb/tb_gba_cart_bus_frontend.sv
// tb/tb_gba_cart_bus_frontend.sv - randomized self-checking bench for gba_cart_bus_frontend
module tb_gba_cart_bus_frontend;
    logic        clk, rst;
    logic        cart_cs_n, cart_rd_n, cart_wr_n;
    logic [15:0] cart_ad_in, cart_ad_out;
    logic [7:0]  cart_a_hi;
    logic        cart_ad_oe, from_cart;
    logic        req_valid, req_ready, req_we;
    logic [25:0] req_addr;
    logic [15:0] req_wdata, rsp_data;
    logic        rsp_valid, underrun, underrun_clr;

    gba_cart_bus_frontend #(.SYNC_STAGES(2), .ADDR_W(26)) dut (
        .clk(clk), .rst(rst),
        .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
        .cart_ad_in(cart_ad_in), .cart_a_hi(cart_a_hi),
        .cart_ad_out(cart_ad_out), .cart_ad_oe(cart_ad_oe), .from_cart(from_cart),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Request log entries: {we, byte address, write data (0 for reads)}
    logic [42:0] obs_q[$];
    logic [42:0] exp_q[$];
    logic [15:0] env_mem[logic [23:0]];
    logic [15:0] mdl_mem[logic [23:0]];
    logic [15:0] pend_data[$];
    int          pend_due[$];
    int          cyc = 0;
    int          rdy_wait = 0;
    logic        rsp_stall = 1'b0;
    logic        ready_block = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fill(input logic [23:0] hw);
        return hw[15:0] ^ {hw[23:16], hw[23:16]} ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] env_rd(input logic [23:0] hw);
        if (env_mem.exists(hw)) return env_mem[hw];
        return fill(hw);
    endfunction

    function automatic logic [15:0] mrd(input logic [23:0] hw);
        if (mdl_mem.exists(hw)) return mdl_mem[hw];
        return fill(hw);
    endfunction

    function automatic logic [23:0] next_hw(input logic [23:0] hw);
        logic [15:0] lo;
        lo = hw[15:0] + 16'd1;
        return {hw[23:16], lo};
    endfunction

    function automatic logic [42:0] mreq(input logic we, input logic [23:0] hw, input logic [15:0] d);
        logic [25:0] byte_addr;
        byte_addr = 26'(hw) * 26'd2;
        return {we, byte_addr, we ? d : 16'h0};
    endfunction

    // Memory side: bounded random accept delay, 1..4 clk in-order read latency.
    initial begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 16'h0;
        forever begin
            @(negedge clk);
            cyc++;
            rsp_valid = 1'b0;
            if (!rst && !rsp_stall && pend_due.size() > 0 && pend_due[0] <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = pend_data.pop_front();
                void'(pend_due.pop_front());
            end
            req_ready = 1'b0;
            if (!rst && req_valid && !ready_block) begin
                if (rdy_wait == 0) begin
                    req_ready = 1'b1;
                    obs_q.push_back({req_we, req_addr, req_we ? req_wdata : 16'h0});
                    if (req_we) env_mem[req_addr[24:1]] = req_wdata;
                    else begin
                        pend_data.push_back(env_rd(req_addr[24:1]));
                        pend_due.push_back(cyc + $urandom_range(1, 4));
                    end
                    rdy_wait = $urandom_range(0, 2);
                end else begin
                    rdy_wait--;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && from_cart; k++) @(negedge clk);
        chk("drain_to_idle", from_cart, 1'b0);
        idle(3);
    endtask

    task automatic cmp_log();
        chk("req_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("req%0d", i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic cs_fall(input logic [23:0] a);
        cart_a_hi  = a[23:16];
        cart_ad_in = a[15:0];
        cart_cs_n  = 1'b0;
        idle(3);
        cart_ad_in = 16'($urandom);
    endtask

    // One CS1 transaction: bit i of wr_ops selects a write (1) or read (0) pulse.
    task automatic txn(input logic [23:0] a, input int n, input logic [7:0] wr_ops);
        logic [23:0] hw;
        logic [15:0] d;
        hw = a;
        exp_q.push_back(mreq(1'b0, hw, 16'h0));
        cs_fall(a);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(6, 10));
            if (wr_ops[i]) begin
                d = 16'($urandom);
                cart_ad_in = d;
                cart_wr_n  = 1'b0;
                idle($urandom_range(12, 16));
                cart_wr_n = 1'b1;
                idle(2);
                exp_q.push_back(mreq(1'b1, hw, d));
                mdl_mem[hw] = d;
            end else begin
                cart_rd_n = 1'b0;
                idle($urandom_range(12, 16));
                chk("ad_oe_on", cart_ad_oe, 1'b1);
                chk("ad_out", cart_ad_out, mrd(hw));
                cart_rd_n = 1'b1;
                idle(4);
                chk("ad_oe_off", cart_ad_oe, 1'b0);
            end
            hw = next_hw(hw);
            exp_q.push_back(mreq(1'b0, hw, 16'h0));
        end
        idle(12);
        cart_cs_n = 1'b1;
        wait_drain();
        cmp_log();
        chk("no_underrun", underrun, 1'b0);
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] hw;
        rst = 1'b1;
        cart_cs_n = 1'b1; cart_rd_n = 1'b1; cart_wr_n = 1'b1;
        cart_ad_in = 16'h0; cart_a_hi = 8'h0; underrun_clr = 1'b0;
        idle(3);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_from_cart", from_cart, 1'b0);
        chk("rst_ad_oe", cart_ad_oe, 1'b0);
        chk("rst_ad_out", cart_ad_out, 16'h0);
        chk("rst_req_addr", req_addr, 26'h0);
        chk("rst_req_we", req_we, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        idle(3);

        txn(24'h123456, 4, 8'h00);
        txn(24'h05FFFF, 1, 8'h00);
        txn(24'h000010, 2, 8'h01);

        // Underrun: two RD pulses while the first response is stalled.
        rsp_stall = 1'b1;
        hw = 24'h000100;
        exp_q.push_back(mreq(1'b0, hw, 16'h0));
        cs_fall(hw);
        idle(6);
        repeat (2) begin
            cart_rd_n = 1'b0; idle(4);
            cart_rd_n = 1'b1; idle(4);
            hw = next_hw(hw);
        end
        idle(4);
        chk("underrun_set", underrun, 1'b1);
        exp_q.push_back(mreq(1'b0, hw, 16'h0));
        idle(12);
        rsp_stall = 1'b0;
        idle(20);
        chk("underrun_sticky", underrun, 1'b1);
        chk("refetch_data", cart_ad_out, mrd(hw));
        underrun_clr = 1'b1; idle(1); underrun_clr = 1'b0;
        chk("underrun_clr", underrun, 1'b0);
        cart_cs_n = 1'b1;
        wait_drain();
        cmp_log();

        // Abort while waiting for a response, RD still low.
        rsp_stall = 1'b1;
        a = 24'($urandom);
        exp_q.push_back(mreq(1'b0, a, 16'h0));
        cs_fall(a);
        cart_rd_n = 1'b0;
        idle(8);
        chk("oe_wait_rsp", cart_ad_oe, 1'b1);
        cart_cs_n = 1'b1;
        idle(4);
        chk("oe_drain", cart_ad_oe, 1'b0);
        chk("drain_busy", from_cart, 1'b1);
        cart_rd_n = 1'b1;
        idle(4);
        rsp_stall = 1'b0;
        wait_drain();
        cmp_log();
        chk("abort_no_underrun", underrun, 1'b0);

        // Abort with the fetch never accepted: request stays presented.
        ready_block = 1'b1;
        a = 24'($urandom);
        exp_q.push_back(mreq(1'b0, a, 16'h0));
        cs_fall(a);
        idle(3);
        cart_cs_n = 1'b1;
        idle(10);
        chk("drain_req_valid", req_valid, 1'b1);
        chk("drain_req_addr", req_addr, mreq(1'b0, a, 16'h0) >> 16);
        ready_block = 1'b0;
        wait_drain();
        cmp_log();

        // Asynchronous reset in the middle of a fetch.
        ready_block = 1'b1;
        a = 24'($urandom);
        cs_fall(a);
        cart_rd_n = 1'b0;
        idle(4);
        chk("fetch_before_rst", req_valid, 1'b1);
        chk("oe_before_rst", cart_ad_oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", req_valid, 1'b0);
        chk("arst_ad_oe", cart_ad_oe, 1'b0);
        chk("arst_from_cart", from_cart, 1'b0);
        cart_cs_n = 1'b1; cart_rd_n = 1'b1;
        @(negedge clk);
        pend_data.delete(); pend_due.delete(); obs_q.delete(); exp_q.delete();
        rdy_wait = 0; ready_block = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(3);
        txn(24'($urandom), 2, 8'h02);

        for (int t = 0; t < 10; t++) begin
            a = 24'($urandom);
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
            txn(a, $urandom_range(1, 6), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
